// File: rtl/baccarat_deal_ctrl.sv
// Baccarat hand sequencer: deals four cards, applies the third-card
// rules, then shows the winner until the next reset.
module baccarat_deal_ctrl (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       done
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    P1     = 4'd1,
    D1     = 4'd2,
    P2     = 4'd3,
    D2     = 4'd4,
    EVAL   = 4'd5,
    P3     = 4'd6,
    EVAL_D = 4'd7,
    D3     = 4'd8,
    DONE   = 4'd9
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] p3_val;
  logic       natural;
  logic       player_low;
  logic       dealer_low;
  logic       banker_draw;

  // Face cards and tens count as zero in the banker table.
  always_comb begin
    p3_val = (pcard3 > 4'd9) ? 4'd0 : pcard3;
  end

  // Opening-hand predicates used by EVAL.
  always_comb begin
    natural = (pscore == 4'd8) || (pscore == 4'd9) ||
              (dscore == 4'd8) || (dscore == 4'd9);
    player_low = (pscore <= 4'd5);
    dealer_low = (dscore <= 4'd5);
  end

  // Banker third-card table after the player has drawn.
  always_comb begin
    banker_draw = 1'b0;
    unique case (1'b1)
      (dscore <= 4'd2):
        banker_draw = 1'b1;
      (dscore == 4'd3):
        banker_draw = (p3_val != 4'd8);
      (dscore == 4'd4):
        banker_draw = (p3_val >= 4'd2) &&
                      (p3_val <= 4'd7);
      (dscore == 4'd5):
        banker_draw = (p3_val >= 4'd4) &&
                      (p3_val <= 4'd7);
      (dscore == 4'd6):
        banker_draw = (p3_val >= 4'd6) &&
                      (p3_val <= 4'd7);
      default:
        banker_draw = 1'b0;
    endcase
  end

  // Next-state: fixed deal order, then the drawing rules.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:   state_nxt = P1;
      P1:     state_nxt = D1;
      D1:     state_nxt = P2;
      P2:     state_nxt = D2;
      D2:     state_nxt = EVAL;
      EVAL: begin
        if (natural)
          state_nxt = DONE;
        else if (player_low)
          state_nxt = P3;
        else if (dealer_low)
          state_nxt = D3;
        else
          state_nxt = DONE;
      end
      P3:     state_nxt = EVAL_D;
      EVAL_D: state_nxt = banker_draw ? D3 : DONE;
      D3:     state_nxt = DONE;
      DONE:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register with outputs registered from the next state.
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state       <= IDLE;
      load_pcard1 <= 1'b0;
      load_pcard2 <= 1'b0;
      load_pcard3 <= 1'b0;
      load_dcard1 <= 1'b0;
      load_dcard2 <= 1'b0;
      load_dcard3 <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      load_pcard1 <= (state_nxt == P1);
      load_pcard2 <= (state_nxt == P2);
      load_pcard3 <= (state_nxt == P3);
      load_dcard1 <= (state_nxt == D1);
      load_dcard2 <= (state_nxt == D2);
      load_dcard3 <= (state_nxt == D3);
      done        <= (state_nxt == DONE);
    end
  end

  // Lights follow the live scores so a final dealer card is counted.
  always_comb begin
    player_win_light = done && (pscore >= dscore);
    dealer_win_light = done && (dscore >= pscore);
  end

endmodule

// File: tb/tb_baccarat_deal_ctrl.sv
// Randomized bench: card-register model feeds scores, a scoreboard
// of whole-hand outcomes is checked by a monitor on the falling edge.
module tb_baccarat_deal_ctrl;

  logic       slow_clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3;
  logic       load_pcard1;
  logic       load_pcard2;
  logic       load_pcard3;
  logic       load_dcard1;
  logic       load_dcard2;
  logic       load_dcard3;
  logic       player_win_light;
  logic       dealer_win_light;
  logic       done;

  baccarat_deal_ctrl dut (
    .slow_clock       (slow_clock),
    .reset            (reset),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light),
    .done             (done)
  );

  always #5 slow_clock = ~slow_clock;

  typedef struct {
    logic [23:0] seq;
    int          cyc;
    logic        pw;
    logic        dw;
  } exp_t;

  exp_t       q[$];
  int         errors = 0;
  int         checks = 0;
  bit         end_req = 1'b0;
  logic [3:0] deck [6];
  logic [3:0] pc1, pc2, pc3, dc1, dc2, dc3;
  logic [5:0] loads;

  function automatic int cv(input logic [3:0] c);
    return (c >= 4'd10) ? 0 : int'(c);
  endfunction

  // Card registers of the scoring datapath, loaded from the deck.
  always @(posedge slow_clock) begin
    if (reset) begin
      {pc1, pc2, pc3, dc1, dc2, dc3} <= '0;
    end else begin
      if (load_pcard1) pc1 <= deck[0];
      if (load_dcard1) dc1 <= deck[1];
      if (load_pcard2) pc2 <= deck[2];
      if (load_dcard2) dc2 <= deck[3];
      if (load_pcard3) pc3 <= deck[4];
      if (load_dcard3) dc3 <= deck[5];
    end
  end

  assign pscore = 4'((cv(pc1) + cv(pc2) + cv(pc3)) % 10);
  assign dscore = 4'((cv(dc1) + cv(dc2) + cv(dc3)) % 10);
  assign pcard3 = pc3;
  assign loads = {load_dcard3, load_dcard2, load_dcard1,
                  load_pcard3, load_pcard2, load_pcard1};

  // Whole-hand reference using punto banco rules.
  function automatic exp_t model();
    exp_t       e;
    int         pv, dv, t;
    bit         ddraw;
    logic [9:0] mask [10];
    mask = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h2FF, 10'h0FC,
             10'h0F0, 10'h0C0, 10'h000, 10'h000, 10'h000};
    pv = (cv(deck[0]) + cv(deck[2])) % 10;
    dv = (cv(deck[1]) + cv(deck[3])) % 10;
    e.seq = 24'h001425;
    e.cyc = 6;
    if (pv < 8 && dv < 8) begin
      if (pv <= 5) begin
        t = cv(deck[4]);
        pv = (pv + t) % 10;
        e.seq = {e.seq[19:0], 4'd3};
        e.cyc += 2;
        ddraw = mask[dv][t];
      end else begin
        ddraw = (dv <= 5);
      end
      if (ddraw) begin
        dv = (dv + cv(deck[5])) % 10;
        e.seq = {e.seq[19:0], 4'd6};
        e.cyc += 1;
      end
    end
    e.pw = (pv >= dv);
    e.dw = (dv >= pv);
    return e;
  endfunction

  // Monitor: reset behaviour, pulse shape, and hand outcomes.
  logic       rst_seen = 1'b1;
  logic [23:0] obs;
  int         cyc;
  logic       done_q;
  logic [5:0] loads_q = '0;
  exp_t       cur;
  bit         have_cur;

  always @(posedge slow_clock) rst_seen <= reset;

  always @(negedge slow_clock) begin
    if (end_req) begin
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL leftover: %0d hands not completed, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end else if (rst_seen) begin
      checks++;
      if (loads != 0 || done || player_win_light || dealer_win_light) begin
        errors++;
        $display("FAIL reset_outputs: loads=%b done=%b pw=%b dw=%b, want all 0",
                 loads, done, player_win_light, dealer_win_light);
      end
      obs = '0;
      cyc = 0;
      done_q = 1'b0;
      have_cur = 1'b0;
    end else begin
      cyc++;
      if (loads[0]) obs = {obs[19:0], 4'd1};
      if (loads[1]) obs = {obs[19:0], 4'd2};
      if (loads[2]) obs = {obs[19:0], 4'd3};
      if (loads[3]) obs = {obs[19:0], 4'd4};
      if (loads[4]) obs = {obs[19:0], 4'd5};
      if (loads[5]) obs = {obs[19:0], 4'd6};
      if (loads != 0) begin
        checks++;
        if (!$onehot(loads) || (loads & loads_q) != 0) begin
          errors++;
          $display("FAIL load_pulse: loads=%b prev=%b, want one single-cycle pulse",
                   loads, loads_q);
        end
      end
      if (done && !done_q) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done rose with no hand expected");
        end else begin
          cur = q.pop_front();
          have_cur = 1'b1;
          checks += 4;
          if (obs != cur.seq) begin
            errors++;
            $display("FAIL load_order: got %h, want %h", obs, cur.seq);
          end
          if (cyc != cur.cyc) begin
            errors++;
            $display("FAIL done_cycle: got %0d, want %0d", cyc, cur.cyc);
          end
          if (player_win_light != cur.pw) begin
            errors++;
            $display("FAIL player_light: got %b, want %b",
                     player_win_light, cur.pw);
          end
          if (dealer_win_light != cur.dw) begin
            errors++;
            $display("FAIL dealer_light: got %b, want %b",
                     dealer_win_light, cur.dw);
          end
        end
      end else if (done && have_cur) begin
        checks++;
        if (player_win_light != cur.pw || dealer_win_light != cur.dw ||
            loads != 0) begin
          errors++;
          $display("FAIL done_hold: pw=%b dw=%b loads=%b, want %b %b 0",
                   player_win_light, dealer_win_light, loads, cur.pw, cur.dw);
        end
      end else if (!done) begin
        checks++;
        if (done_q || player_win_light || dealer_win_light) begin
          errors++;
          $display("FAIL idle_lights: done_prev=%b pw=%b dw=%b, want 0",
                   done_q, player_win_light, dealer_win_light);
        end
        if (cyc == 40) begin
          checks++;
          errors++;
          $display("FAIL timeout: no done after %0d cycles, want done", cyc);
        end
      end
      done_q = done;
    end
    loads_q = loads;
  end

  // Load enables are mutually exclusive single-cycle pulses.
  logic [5:0] loads_a = '0;
  always @(negedge slow_clock) begin
    a_onehot: assert ($onehot0(loads))
      else $error("two load enables high together: %b", loads);
    a_width: assert ((loads & loads_a) == 0)
      else $error("load pulse wider than one cycle: %b", loads);
    loads_a <= loads;
  end

  task automatic set_deck(input int p1, d1, p2, d2, p3, d3);
    deck[0] = 4'(p1);
    deck[1] = 4'(d1);
    deck[2] = 4'(p2);
    deck[3] = 4'(d2);
    deck[4] = 4'(p3);
    deck[5] = 4'(d3);
  endtask

  task automatic run_hand(input bit abort);
    @(negedge slow_clock);
    #1 reset = 1'b1;
    repeat (3) @(negedge slow_clock);
    if (abort) begin
      #1 reset = 1'b0;
      for (int i = 0; i < 20 && !load_pcard3; i++)
        @(negedge slow_clock);
      #1 reset = 1'b1;
      repeat (2) @(negedge slow_clock);
    end
    q.push_back(model());
    #1 reset = 1'b0;
    for (int i = 0; i < 45 && !done; i++)
      @(negedge slow_clock);
    repeat (3) @(negedge slow_clock);
  endtask

  // Directed hands first, then random shoes with occasional aborts.
  initial begin
    set_deck(0, 0, 0, 0, 0, 0);
    set_deck(4, 1, 5, 3, 7, 7);
    run_hand(1'b0);
    set_deck(3, 1, 3, 2, 9, 4);
    run_hand(1'b0);
    set_deck(1, 3, 1, 3, 7, 13);
    run_hand(1'b0);
    set_deck(1, 3, 1, 3, 12, 5);
    run_hand(1'b0);
    set_deck(2, 2, 3, 3, 10, 9);
    run_hand(1'b0);
    set_deck(1, 3, 1, 3, 7, 13);
    run_hand(1'b1);
    for (int h = 0; h < 60; h++) begin
      for (int k = 0; k < 6; k++)
        deck[k] = 4'($urandom_range(1, 13));
      run_hand((h % 7 == 3) && (cv(deck[0]) + cv(deck[2])) % 10 <= 5 &&
               (cv(deck[1]) + cv(deck[3])) % 10 < 8);
    end
    @(negedge slow_clock);
    #1 end_req = 1'b1;
    repeat (5) @(negedge slow_clock);
    $display("FAIL end_of_test: monitor did not finish");
    $fatal(1, "bench stalled");
  end

endmodule
